// File: rtl/conv_loop_sequencer_pkg.sv
// Shared definitions for the conv loop sequencer: one-hot state encoding,
// control-word bit positions and a packing helper.
package conv_seq_pkg;

    localparam int CTRL_W     = 23;
    localparam int NUM_STATES = 9;

    localparam int ST_IDLE  = 0;
    localparam int ST_LCLR  = 1;
    localparam int ST_CLR   = 2;
    localparam int ST_LOAD  = 3;
    localparam int ST_RUN   = 4;
    localparam int ST_STEP  = 5;
    localparam int ST_STORE = 6;
    localparam int ST_NEXT  = 7;
    localparam int ST_DONE  = 8;

    typedef enum logic [NUM_STATES-1:0] {
        S_IDLE  = 9'h001,
        S_LCLR  = 9'h002,
        S_CLR   = 9'h004,
        S_LOAD  = 9'h008,
        S_RUN   = 9'h010,
        S_STEP  = 9'h020,
        S_STORE = 9'h040,
        S_NEXT  = 9'h080,
        S_DONE  = 9'h100
    } seq_state_e;

    localparam int ACT_SIZE_MSB   = 22;
    localparam int ACT_SIZE_LSB   = 18;
    localparam int FILT_SIZE_MSB  = 17;
    localparam int FILT_SIZE_LSB  = 15;
    localparam int RESET_RAM_ADDR = 14;
    localparam int RESET_ROM_ADDR = 13;
    localparam int RESET_MCC      = 12;
    localparam int RESET_DATA     = 11;
    localparam int LAYER          = 10;
    localparam int CHANNEL_MSB    = 9;
    localparam int CHANNEL_LSB    = 6;
    localparam int DIM_MSB        = 5;
    localparam int DIM_LSB        = 3;
    localparam int FIRST_IN       = 2;
    localparam int WRITE_FIRST    = 1;
    localparam int LOAD_DATA      = 0;

    function automatic logic [CTRL_W-1:0] ctrl_pack(
        input logic [4:0] act_size,
        input logic [2:0] filter_size,
        input logic       reset_ram_address,
        input logic       reset_rom_address,
        input logic       reset_mcc,
        input logic       reset_data,
        input logic       layer,
        input logic [3:0] channel,
        input logic [2:0] dimension,
        input logic       first_in,
        input logic       write_first,
        input logic       load_data
    );
        return {act_size, filter_size, reset_ram_address, reset_rom_address,
                reset_mcc, reset_data, layer, channel, dimension,
                first_in, write_first, load_data};
    endfunction

endpackage

// File: rtl/conv_loop_sequencer_if.sv
// Host/datapath handshake bundle of the conv loop sequencer.
// SEQ_PERF_CNT_EN adds the cyc_cnt/stall_cnt performance counters.
interface conv_loop_sequencer_if
    import conv_seq_pkg::*;
();
    logic                  start;
    logic                  run_mcc;
    logic                  mcc_done;
    logic                  ppu_done;
    logic [CTRL_W-1:0]     control_signal;
    logic                  idle;
    logic                  finish;
    logic [NUM_STATES-1:0] state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]           cyc_cnt;
    logic [31:0]           stall_cnt;

    modport master (
        input  start, run_mcc, mcc_done, ppu_done,
        output control_signal, idle, finish, state, cyc_cnt, stall_cnt
    );
    modport slave (
        output start, run_mcc, mcc_done, ppu_done,
        input  control_signal, idle, finish, state, cyc_cnt, stall_cnt
    );
`else
    modport master (
        input  start, run_mcc, mcc_done, ppu_done,
        output control_signal, idle, finish, state
    );
    modport slave (
        output start, run_mcc, mcc_done, ppu_done,
        input  control_signal, idle, finish, state
    );
`endif
endinterface

// File: rtl/conv_loop_sequencer_counter.sv
// Channel and filter-row counters with terminal compares; increments are
// ignored at the terminal value so neither counter can wrap.
module seq_loop_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       ch_inc,
    input  logic       ch_clr,
    input  logic       dim_inc,
    input  logic       dim_clr,
    input  logic [4:0] num_ch,
    input  logic [2:0] filter_size,
    output logic [3:0] channel,
    output logic [2:0] dimension,
    output logic       ch_last,
    output logic       dim_last
);

    assign ch_last  = ({1'b0, channel} + 5'd1) == num_ch;
    assign dim_last = ({1'b0, dimension} + 4'd1) == {1'b0, filter_size};

    always_ff @(posedge clk) begin
        if (reset || ch_clr)
            channel <= '0;
        else if (ch_inc && !ch_last)
            channel <= channel + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset || dim_clr)
            dimension <= '0;
        else if (dim_inc && !dim_last)
            dimension <= dimension + 3'd1;
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Layer -> output channel -> filter row loop walker driving the sparse conv
// datapath control word. SEQ_PERF_CNT_EN adds cycle/stall performance counters.
module conv_loop_sequencer
    import conv_seq_pkg::*;
#(
    parameter int L0_ACT_SIZE  = 16,
    parameter int L0_FILT_SIZE = 3,
    parameter int L0_NUM_CH    = 4,
    parameter int L1_ACT_SIZE  = 7,
    parameter int L1_FILT_SIZE = 3,
    parameter int L1_NUM_CH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_loop_sequencer_if.master  bus
);

    seq_state_e state_q;
    logic       layer_q;
    logic [4:0] act_size;
    logic [2:0] filter_size;
    logic [4:0] num_ch;
    logic [3:0] channel;
    logic [2:0] dimension;
    logic       ch_last;
    logic       dim_last;
    logic       ch_inc;
    logic       ch_clr;
    logic       dim_inc;
    logic       dim_clr;
    logic       in_idle;

    always_comb begin
        act_size    = layer_q ? 5'(L1_ACT_SIZE)  : 5'(L0_ACT_SIZE);
        filter_size = layer_q ? 3'(L1_FILT_SIZE) : 3'(L0_FILT_SIZE);
        num_ch      = layer_q ? 5'(L1_NUM_CH)    : 5'(L0_NUM_CH);
    end

    // Channel survives the last S_NEXT of layer 1 so S_DONE still shows it.
    assign dim_inc = (state_q == S_STEP);
    assign dim_clr = (state_q == S_STORE && bus.ppu_done) || (state_q == S_DONE);
    assign ch_inc  = (state_q == S_NEXT) && !ch_last;
    assign ch_clr  = ((state_q == S_NEXT) && ch_last && !layer_q) || (state_q == S_DONE);

    seq_loop_counter u_cnt (
        .clk         (clk),
        .reset       (reset),
        .ch_inc      (ch_inc),
        .ch_clr      (ch_clr),
        .dim_inc     (dim_inc),
        .dim_clr     (dim_clr),
        .num_ch      (num_ch),
        .filter_size (filter_size),
        .channel     (channel),
        .dimension   (dimension),
        .ch_last     (ch_last),
        .dim_last    (dim_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            layer_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start) state_q <= S_LCLR;
                S_LCLR:  state_q <= S_CLR;
                S_CLR:   state_q <= S_LOAD;
                S_LOAD:  if (bus.run_mcc) state_q <= S_RUN;
                S_RUN:   if (bus.mcc_done) state_q <= dim_last ? S_STORE : S_STEP;
                S_STEP:  state_q <= S_CLR;
                S_STORE: if (bus.ppu_done) state_q <= S_NEXT;
                S_NEXT: begin
                    if (!ch_last) begin
                        state_q <= S_CLR;
                    end else if (!layer_q) begin
                        layer_q <= 1'b1;
                        state_q <= S_LCLR;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    layer_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; sizes read zero while idle.
    assign in_idle = (state_q == S_IDLE);

    always_comb begin
        bus.control_signal = ctrl_pack(
            in_idle ? 5'd0 : act_size,
            in_idle ? 3'd0 : filter_size,
            state_q == S_LCLR,
            state_q == S_CLR,
            (state_q == S_CLR) && (dimension == 3'd0),
            state_q == S_CLR,
            layer_q,
            channel,
            dimension,
            (state_q == S_LOAD) && !layer_q,
            (state_q == S_STORE) && layer_q,
            state_q == S_LOAD
        );
        bus.idle   = in_idle;
        bus.finish = (state_q == S_DONE);
        bus.state  = state_q;
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset || (in_idle && bus.start)) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (!in_idle && cyc_q != '1)
                cyc_q <= cyc_q + 32'd1;
            if ((state_q == S_LOAD || state_q == S_STORE) && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.cyc_cnt   = cyc_q;
    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench for conv_loop_sequencer: 2-channel layer 0, 1-channel layer 1,
// datapath responder echoing handshakes two cycles after each request.
module tb_conv_loop_sequencer;
    import conv_seq_pkg::*;

    typedef struct {
        logic       layer;
        logic [3:0] ch;
        logic [2:0] dim;
    } clr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_loop_sequencer_if bus();

    conv_loop_sequencer #(
        .L0_ACT_SIZE(16), .L0_FILT_SIZE(3), .L0_NUM_CH(2),
        .L1_ACT_SIZE(7),  .L1_FILT_SIZE(3), .L1_NUM_CH(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit go = 0;
    bit stray_en = 0;
    bit mon_en = 0;

    clr_t       exp_clr[$];
    logic       exp_store[$];
    logic [4:0] exp_lclr[$];
    int         exp_fin[$];

    int load_bursts = 0, rmcc_cnt = 0, rram_cnt = 0, fin_cnt = 0, wf_l0_cnt = 0;
    int meas_cyc = 0, meas_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Datapath responder: owns every input except the bench-level go flag.
    initial begin : responder
        logic [8:0] prev_st;
        int         cnt;
        bit         pend;
        logic [8:0] pend_st;
        prev_st = '0; cnt = 0; pend = 0; pend_st = '0;
        bus.start = 0; bus.run_mcc = 0; bus.mcc_done = 0; bus.ppu_done = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("stray_hold", bus.state, pend_st);
                pend = 0;
            end
            if (bus.state != prev_st) cnt = 0;
            cnt++;
            prev_st = bus.state;
            bus.run_mcc = 0; bus.mcc_done = 0; bus.ppu_done = 0;
            bus.start = go;
            if (bus.state == S_LOAD) begin
                if (cnt == 2) bus.run_mcc = 1;
                else if (stray_en && cnt == 1) begin
                    bus.mcc_done = 1; pend = 1; pend_st = bus.state;
                end
            end else if (bus.state == S_RUN) begin
                if (cnt == 2) bus.mcc_done = 1;
                else if (stray_en && cnt == 1) begin
                    bus.ppu_done = 1; bus.start = 1; pend = 1; pend_st = bus.state;
                end
            end else if (bus.state == S_STORE) begin
                if (cnt == 2) bus.ppu_done = 1;
            end
        end
    end

    // Monitor: pulse counters plus scoreboard pops on each DUT event.
    initial begin : monitor
        logic [CTRL_W-1:0] cs;
        logic              prev_load;
        logic [8:0]        prev_st;
        clr_t              e;
        logic              wf;
        logic [4:0]        a;
        prev_load = 0; prev_st = '0;
        forever begin
            @(negedge clk);
            cs = bus.control_signal;
            if (cs[LOAD_DATA] && !prev_load) load_bursts++;
            prev_load = cs[LOAD_DATA];
            if (cs[RESET_MCC]) rmcc_cnt++;
            if (cs[RESET_RAM_ADDR]) rram_cnt++;
            if (cs[WRITE_FIRST] && !cs[LAYER]) wf_l0_cnt++;
            if (bus.state != S_IDLE) meas_cyc++;
            if (bus.state == S_LOAD || bus.state == S_STORE) meas_stall++;
            if (bus.finish) begin
                fin_cnt++;
                if (mon_en) begin
                    if (exp_fin.size() == 0) chk("finish_unexpected", 1, 0);
                    else void'(exp_fin.pop_front());
                end
            end
            if (mon_en && bus.state == S_CLR) begin
                if (exp_clr.size() == 0) chk("clr_unexpected", 1, 0);
                else begin
                    e = exp_clr.pop_front();
                    chk("clr_layer", cs[LAYER], e.layer);
                    chk("clr_channel", cs[CHANNEL_MSB:CHANNEL_LSB], e.ch);
                    chk("clr_dim", cs[DIM_MSB:DIM_LSB], e.dim);
                    chk("clr_reset_mcc", cs[RESET_MCC], e.dim == 3'd0);
                    chk("clr_reset_rom", cs[RESET_ROM_ADDR], 1);
                    chk("clr_reset_data", cs[RESET_DATA], 1);
                    chk("clr_act_size", cs[ACT_SIZE_MSB:ACT_SIZE_LSB], e.layer ? 7 : 16);
                    chk("clr_filt_size", cs[FILT_SIZE_MSB:FILT_SIZE_LSB], 3);
                end
            end
            if (mon_en && bus.state == S_LCLR) begin
                if (exp_lclr.size() == 0) chk("lclr_unexpected", 1, 0);
                else begin
                    a = exp_lclr.pop_front();
                    chk("lclr_act_size", cs[ACT_SIZE_MSB:ACT_SIZE_LSB], a);
                end
            end
            if (mon_en && bus.state == S_STORE && prev_st != S_STORE) begin
                if (exp_store.size() == 0) chk("store_unexpected", 1, 0);
                else begin
                    wf = exp_store.pop_front();
                    chk("store_write_first", cs[WRITE_FIRST], wf);
                end
            end
            prev_st = bus.state;
        end
    end

    task automatic wait_accept(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.state != S_IDLE) begin ok = 1; break; end
        end
        go = 0;
        if (!ok) chk(nm, 0, 1);
    endtask

    initial begin : main
        int base_fin, base_load, base_rmcc, base_rram, base_cyc, base_stall;
        bit ok;
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_state", bus.state, 9'h001);
        chk("rst_ctrl", bus.control_signal, 0);
        chk("rst_idle", bus.idle, 1);
        chk("rst_finish", bus.finish, 0);

        // Abort mid-S_LOAD in layer 1, second row.
        go = 1;
        wait_accept("abort_accept");
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.state == S_LOAD && bus.control_signal[LAYER] &&
                bus.control_signal[DIM_MSB:DIM_LSB] == 3'd1) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("abort_reach", ok, 1);
        reset = 1;
        @(negedge clk);
        chk("abort_state", bus.state, 9'h001);
        chk("abort_ctrl", bus.control_signal, 0);
        chk("abort_idle", bus.idle, 1);
        chk("abort_finish", bus.finish, 0);
        reset = 0;
        base_fin = fin_cnt;
        repeat (20) @(negedge clk);
        chk("abort_no_finish", fin_cnt - base_fin, 0);
        chk("abort_stays_idle", bus.state, 9'h001);

        // Full run with stray pulses injected.
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < (l == 0 ? 2 : 1); c++) begin
                for (int d = 0; d < 3; d++) exp_clr.push_back('{l[0], c[3:0], d[2:0]});
                exp_store.push_back(l == 1);
            end
        exp_lclr.push_back(5'd16);
        exp_lclr.push_back(5'd7);
        exp_fin.push_back(1);
        base_fin = fin_cnt; base_load = load_bursts; base_rmcc = rmcc_cnt;
        base_rram = rram_cnt; base_cyc = meas_cyc; base_stall = meas_stall;
        mon_en = 1;
        stray_en = 1;
        go = 1;
        wait_accept("run_accept");
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fin_cnt > base_fin && bus.state == S_IDLE) begin ok = 1; break; end
        end
        chk("run_completes", ok, 1);
        repeat (5) @(negedge clk);
        stray_en = 0;
        mon_en = 0;
        chk("run_load_bursts", load_bursts - base_load, 9);
        chk("run_reset_mcc", rmcc_cnt - base_rmcc, 3);
        chk("run_reset_ram", rram_cnt - base_rram, 2);
        chk("run_finish", fin_cnt - base_fin, 1);
        chk("run_wf_layer0", wf_l0_cnt, 0);
        chk("run_clr_left", exp_clr.size(), 0);
        chk("run_store_left", exp_store.size(), 0);
        chk("run_lclr_left", exp_lclr.size(), 0);
        chk("run_fin_left", exp_fin.size(), 0);
        chk("run_idle_ctrl", bus.control_signal, 0);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_cyc", bus.cyc_cnt, meas_cyc - base_cyc);
        chk("perf_stall", bus.stall_cnt, meas_stall - base_stall);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
